param_stack: RTL

//  Parametrised LIFO operand stack for the multicycle stack-machine datapath.

---
 rtl/param_stack.sv | 101 ++++++++++
 1 files changed

// File: rtl/param_stack.sv
// Parametrised LIFO operand stack with replace-top (push+pop), occupancy count and sticky error flags.
// Latency: dout/dout_valid register on the edge a command is sampled, visible the following cycle.
// Backpressure: none; overflowing pushes and empty reads are dropped and recorded in sticky flags.
module param_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             push,
    input  logic             pop,
    input  logic             tos,
    input  logic             clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];

    logic             notEmpty;
    logic [AW-1:0]    topIdx;
    logic [AW-1:0]    pushIdx;
    logic [AW-1:0]    wrIdx;
    logic             rdReq;
    logic             rdOk;
    logic             popOk;
    logic             wrEn;
    logic             ovfSet;
    logic             unfSet;
    logic [CNT_W-1:0] nextCount;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign notEmpty = !empty;

    // topIdx wraps when empty, but it is only consumed when the stack is occupied
    assign topIdx  = AW'(count - CNT_W'(1));
    assign pushIdx = AW'(count);

    assign rdReq  = pop | tos;
    assign rdOk   = rdReq & notEmpty;
    assign popOk  = pop & notEmpty;
    assign unfSet = rdReq & empty;

    // A pop frees the top slot in the same cycle, so push+pop is legal even when full
    assign wrEn   = push & (popOk | !full);
    assign wrIdx  = popOk ? topIdx : pushIdx;
    assign ovfSet = push & !popOk & full;

    always_comb begin
        nextCount = count;
        if (popOk && !push) begin
            nextCount = count - CNT_W'(1);
        end else if (push && !popOk && !full) begin
            nextCount = count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (clr) begin
            count      <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            count      <= nextCount;
            dout_valid <= rdOk;
            if (rdOk) begin
                dout <= mem[topIdx];
            end
            if (ovfSet) begin
                overflow <= 1'b1;
            end
            if (unfSet) begin
                underflow <= 1'b1;
            end
        end
    end

    // Storage carries no reset; unoccupied entries are don't-care
    always_ff @(posedge clk) begin
        if (rst && !clr && wrEn) begin
            mem[wrIdx] <= din;
        end
    end

endmodule
